mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single main-memory port between the instruction-cache and data-cache miss engines of the three-stage core. Accepts one line-granularity transaction at a time: an icache line fill, a dcache line fill, or a dcache writeback. It then sequences the memory request, write-data and read-response phases beat by beat and routes the response to the owning requester. Sits between the cache controllers and the memory model/DRAM interface, below the core's `stall` generation.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 41 ++++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arb_pkg                                            |
// | Description : Shared encodings for the cache/memory arbiter: FSM     |
// |               states, grant owner and memory read/write direction.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RDATA = 2'd3
   } state_e;

   // Grant owner; the value doubles as the index into the req/gnt vectors
   localparam logic GNT_IC = 1'b0;
   localparam logic GNT_DC = 1'b1;

   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arb2                                                |
// | Description : Two-input round-robin arbiter. A lone requester wins;  |
// |               on a tie the requester not granted last time wins.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic last_q;

   // One-hot grant selection from the current requests and last owner
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_q == GNT_IC) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // Remember the owner of every accepted grant; reset favours dcache next
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= GNT_IC;
      end else if (accept && (gnt != 2'b00)) begin
         last_q <= gnt[1];
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arbiter                                            |
// | Description : Shares one main-memory port between the icache and     |
// |               dcache miss engines, one cache-line transaction at a   |
// |               time, with pass-through write and response beats.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128,
   parameter int BEATS  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req_valid,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_req_ready,
   output logic              ic_resp_valid,
   output logic [DATA_W-1:0] ic_resp_data,
   output logic              ic_resp_last,
   input  logic              dc_req_valid,
   input  logic              dc_req_rw,
   input  logic [ADDR_W-1:0] dc_req_addr,
   output logic              dc_req_ready,
   input  logic              dc_wdata_valid,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_wdata_ready,
   output logic              dc_resp_valid,
   output logic [DATA_W-1:0] dc_resp_data,
   output logic              dc_resp_last,
   output logic              dc_wr_done,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_wdata_valid,
   input  logic              mem_wdata_ready,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              busy
);

   localparam int                LINE_OFF  = $clog2(BEATS * DATA_W / 8);
   localparam int                CNT_W     = $clog2(BEATS);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));

   state_e            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              rw_q, rw_d;
   logic              req_valid_q, req_valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        w_gnt;
   logic              w_is_last;

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .reset  (reset),
      .req    ({dc_req_valid, ic_req_valid}),
      .accept (state_q == ST_IDLE),
      .gnt    (w_gnt)
   );

   assign w_is_last     = (cnt_q == LAST_BEAT);
   assign mem_req_valid = req_valid_q;
   assign mem_req_rw    = rw_q;
   assign mem_req_addr  = addr_q;
   assign busy          = (state_q != ST_IDLE);

   // Next-state, latch updates and all combinational handshake/routing outputs
   always_comb begin
      state_d         = state_q;
      gnt_d           = gnt_q;
      rw_d            = rw_q;
      req_valid_d     = req_valid_q;
      addr_d          = addr_q;
      cnt_d           = cnt_q;
      ic_req_ready    = 1'b0;
      dc_req_ready    = 1'b0;
      ic_resp_valid   = 1'b0;
      ic_resp_data    = '0;
      ic_resp_last    = 1'b0;
      dc_resp_valid   = 1'b0;
      dc_resp_data    = '0;
      dc_resp_last    = 1'b0;
      dc_wdata_ready  = 1'b0;
      dc_wr_done      = 1'b0;
      mem_wdata_valid = 1'b0;
      mem_wdata       = '0;
      case (state_q)
         ST_IDLE: begin
            ic_req_ready = w_gnt[0];
            dc_req_ready = w_gnt[1];
            if (w_gnt != 2'b00) begin
               gnt_d       = w_gnt[1];
               rw_d        = w_gnt[1] ? dc_req_rw : MEM_RD;
               addr_d      = (w_gnt[1] ? dc_req_addr : ic_req_addr) & LINE_MASK;
               req_valid_d = 1'b1;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               req_valid_d = 1'b0;
               cnt_d       = '0;
               state_d     = (rw_q == MEM_WR) ? ST_WDATA : ST_RDATA;
            end
         end
         ST_WDATA: begin
            mem_wdata_valid = dc_wdata_valid;
            dc_wdata_ready  = mem_wdata_ready;
            mem_wdata       = dc_wdata_valid ? dc_wdata : '0;
            if (dc_wdata_valid && mem_wdata_ready) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (w_is_last) begin
                  dc_wr_done = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
         end
         ST_RDATA: begin
            if (mem_resp_valid) begin
               if (gnt_q == GNT_IC) begin
                  ic_resp_valid = 1'b1;
                  ic_resp_data  = mem_resp_data;
                  ic_resp_last  = w_is_last;
               end else begin
                  dc_resp_valid = 1'b1;
                  dc_resp_data  = mem_resp_data;
                  dc_resp_last  = w_is_last;
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (w_is_last) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and transaction latches; reset abandons any transfer in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         gnt_q       <= GNT_IC;
         rw_q        <= MEM_RD;
         req_valid_q <= 1'b0;
         addr_q      <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         rw_q        <= rw_d;
         req_valid_q <= req_valid_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                         |
// | Description : Directed self-checking bench for mem_arbiter.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         ic_req_valid, ic_req_ready, ic_resp_valid, ic_resp_last;
   logic [31:0]  ic_req_addr;
   logic [127:0] ic_resp_data;
   logic         dc_req_valid, dc_req_rw, dc_req_ready, dc_wdata_valid, dc_wdata_ready;
   logic [31:0]  dc_req_addr;
   logic [127:0] dc_wdata, dc_resp_data;
   logic         dc_resp_valid, dc_resp_last, dc_wr_done;
   logic         mem_req_valid, mem_req_ready, mem_req_rw;
   logic [31:0]  mem_req_addr;
   logic         mem_wdata_valid, mem_wdata_ready, mem_resp_valid;
   logic [127:0] mem_wdata, mem_resp_data;
   logic         busy;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(128), .BEATS(4)) dut (
      .clk(clk), .reset(reset),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_last(ic_resp_last),
      .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
      .dc_req_ready(dc_req_ready), .dc_wdata_valid(dc_wdata_valid), .dc_wdata(dc_wdata),
      .dc_wdata_ready(dc_wdata_ready), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .dc_resp_last(dc_resp_last), .dc_wr_done(dc_wr_done),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid),
      .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] rbeat(input int n);
      return {32'hAAAA_0000 + n, 32'h1111_1111 * (n + 1), 32'h0F0F_0F0F, 32'h0000_00A0 + n};
   endfunction

   function automatic logic [127:0] wbeat(input int n);
      return {32'hBBBB_0000 + n, 32'h2222_2222 * (n + 1), 32'hF0F0_F0F0, 32'h0000_00B0 + n};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in the first REQ cycle: optional request stall, then 4 read beats
   task automatic do_read(input bit is_ic, input logic [31:0] exp_addr, input int stall);
      chk("req_valid", mem_req_valid, 1'b1);
      chk("req_addr", mem_req_addr, exp_addr);
      chk("req_rw", mem_req_rw, 1'b0);
      chk("busy_req", busy, 1'b1);
      for (int s = 0; s < stall; s++) begin
         mem_req_ready = 1'b0;
         #1;
         chk("stall_valid", mem_req_valid, 1'b1);
         chk("stall_addr", mem_req_addr, exp_addr);
         chk("stall_ic_rdy", ic_req_ready, 1'b0);
         chk("stall_dc_rdy", dc_req_ready, 1'b0);
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #1;
      chk("req_valid_drop", mem_req_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = rbeat(i);
         #1;
         chk("ic_resp_valid", ic_resp_valid, is_ic);
         chk("dc_resp_valid", dc_resp_valid, !is_ic);
         chk("resp_data", is_ic ? ic_resp_data : dc_resp_data, rbeat(i));
         chk("resp_last", is_ic ? ic_resp_last : dc_resp_last, (i == 3));
         tick();
      end
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      #1;
      chk("busy_after_read", busy, 1'b0);
   endtask

   initial begin
      bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int n;
      reset = 1'b1;
      ic_req_valid = 0; ic_req_addr = '0; dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
      dc_wdata_valid = 0; dc_wdata = '0; mem_req_ready = 0; mem_wdata_ready = 0;
      mem_resp_valid = 0; mem_resp_data = '0;
      #2;
      chk("rst_busy", busy, 1'b0);
      chk("rst_req_valid", mem_req_valid, 1'b0);
      chk("rst_req_rw", mem_req_rw, 1'b0);
      chk("rst_req_addr", mem_req_addr, 32'h0);
      chk("rst_ic_ready", ic_req_ready, 1'b0);
      chk("rst_dc_wr_done", dc_wr_done, 1'b0);
      tick();
      tick();
      reset = 1'b0;

      // Tie after reset: dcache fill wins, with a 5-cycle request stall
      ic_req_valid = 1; ic_req_addr = 32'h1000_0014;
      dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 32'h2000_0047;
      #1;
      chk("tie1_dc_ready", dc_req_ready, 1'b1);
      chk("tie1_ic_ready", ic_req_ready, 1'b0);
      tick();
      dc_req_valid = 0;
      do_read(1'b0, 32'h2000_0040, 5);

      // icache still waiting; a new tie now goes to icache
      dc_req_valid = 1;
      #1;
      chk("tie2_ic_ready", ic_req_ready, 1'b1);
      chk("tie2_dc_ready", dc_req_ready, 1'b0);
      tick();
      ic_req_valid = 0;
      do_read(1'b1, 32'h1000_0000, 0);

      // Next tie goes to dcache: a writeback with a toggling write-ready
      ic_req_valid = 1; dc_req_rw = 1; dc_req_addr = 32'h3000_0088;
      #1;
      chk("tie3_dc_ready", dc_req_ready, 1'b1);
      chk("tie3_ic_ready", ic_req_ready, 1'b0);
      tick();
      dc_req_valid = 0; dc_req_rw = 0;
      chk("wr_req_rw", mem_req_rw, 1'b1);
      chk("wr_req_addr", mem_req_addr, 32'h3000_0080);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         dc_wdata_valid  = 1;
         dc_wdata        = wbeat(n);
         mem_wdata_ready = pat[k];
         #1;
         chk("wd_valid", mem_wdata_valid, 1'b1);
         chk("wd_data", mem_wdata, wbeat(n));
         chk("wd_ready", dc_wdata_ready, pat[k]);
         chk("wr_done", dc_wr_done, (pat[k] && n == 3));
         chk("wd_ic_ready", ic_req_ready, 1'b0);
         if (pat[k]) n++;
         tick();
      end
      dc_wdata_valid = 0; dc_wdata = '0; mem_wdata_ready = 0;
      #1;
      chk("wr_busy_fall", busy, 1'b0);
      chk("wr_done_clear", dc_wr_done, 1'b0);

      // Fourth tie: icache again
      dc_req_valid = 1;
      #1;
      chk("tie4_ic_ready", ic_req_ready, 1'b1);
      chk("tie4_dc_ready", dc_req_ready, 1'b0);
      tick();
      ic_req_valid = 0; dc_req_valid = 0;
      do_read(1'b1, 32'h1000_0000, 0);

      // Reset in the middle of a dcache fill (last grant dcache before reset)
      dc_req_valid = 1; dc_req_addr = 32'h4000_00FF;
      tick();
      dc_req_valid = 0;
      chk("mid_req_addr", mem_req_addr, 32'h4000_00C0);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      for (int i = 0; i < 2; i++) begin
         mem_resp_valid = 1; mem_resp_data = rbeat(i);
         tick();
      end
      mem_resp_data = rbeat(2);
      reset = 1'b1;
      #1;
      chk("mid_busy", busy, 1'b0);
      chk("mid_dc_resp_valid", dc_resp_valid, 1'b0);
      chk("mid_dc_resp_last", dc_resp_last, 1'b0);
      chk("mid_dc_resp_data", dc_resp_data, 128'h0);
      chk("mid_req_valid", mem_req_valid, 1'b0);
      chk("mid_req_addr_rst", mem_req_addr, 32'h0);
      mem_resp_valid = 0; mem_resp_data = '0;
      tick();
      reset = 1'b0;
      ic_req_valid = 1; dc_req_valid = 1;
      #1;
      chk("post_rst_dc_ready", dc_req_ready, 1'b1);
      chk("post_rst_ic_ready", ic_req_ready, 1'b0);
      ic_req_valid = 0; dc_req_valid = 0;

      // Stray response while idle
      mem_resp_valid = 1; mem_resp_data = rbeat(7);
      #1;
      chk("stray_ic_valid", ic_resp_valid, 1'b0);
      chk("stray_dc_valid", dc_resp_valid, 1'b0);
      tick();
      mem_resp_valid = 0; mem_resp_data = '0;
      #1;
      chk("stray_busy", busy, 1'b0);
      chk("stray_req_valid", mem_req_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
